// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit: single-outstanding load/store sequencer in front of the
// memory controller. It latches a request, issues one single-cycle read or
// write strobe, waits READ_LATENCY cycles for load data and returns it over
// a valid/ready response channel. Control outputs are decoded from the state
// register only.
module mem_access_unit #(
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1   // legal range 1..8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            o_action,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_READ  = 2'b01;
  localparam logic [1:0] ACT_WRITE = 2'b10;

  // Count value reached in the WAIT cycle during which i_data is valid.
  localparam logic [3:0] LAST_CNT = 4'(READ_LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // State and datapath registers; everything returns to its idle value on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    o_action  = ACT_NONE;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_write) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_ISSUE;
            cnt_d   = '0;
          end
        end
      end
      S_WRITE: begin
        o_action = ACT_WRITE;
        state_d  = S_IDLE;
      end
      S_ISSUE: begin
        o_action = ACT_READ;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          rdata_d = i_data;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_address = addr_q;
  assign o_data    = wdata_q;
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer that sits directly upstream of the core's memory controller. It accepts one load or store request at a time from the core execute stage over a valid/ready handshake. It drives the controller's 2-bit action, address and write-data inputs with correctly timed single-cycle strobes. For loads it waits a fixed read latency, captures the controller's read data, and returns it over a valid/ready response channel.

## Interface
- DATA_WIDTH, 16, width of address and data buses
- READ_LATENCY, 1, cycles from the read-strobe cycle to the cycle in which `i_data` is valid; legal range 1..8

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  DATA_WIDTH  request address
- req_wdata  in  DATA_WIDTH  store data
- rsp_valid  out  1  load data available
- rsp_ready  in  1  core accepts load data
- rsp_rdata  out  DATA_WIDTH  load data
- o_action  out  2  to controller action input; bit0 = read strobe, bit1 = write strobe
- o_address  out  DATA_WIDTH  to controller address input
- o_data  out  DATA_WIDTH  to controller write-data input
- i_data  in  DATA_WIDTH  from controller read-data output
- busy  out  1  state != IDLE

## Operation
- **States:** IDLE, WRITE, ISSUE, WAIT, RESP; state held in a register.
- **IDLE:**
  - req_ready = 1.
  - On req_valid: latch req_addr into o_address and req_wdata into o_data.
  - Next state is WRITE if req_write = 1, else ISSUE with wait counter cleared.
- **WRITE:**
  - o_action = 2'b10 for exactly this one cycle.
  - Next state is IDLE.
  - Stores produce no response.
- **ISSUE:**
  - o_action = 2'b01 for exactly this one cycle.
  - Next state is WAIT.
- **WAIT:**
  - o_action = 2'b00.
  - Counter increments each cycle.
  - In the cycle where counter == READ_LATENCY-1, capture i_data into rsp_rdata at the closing edge and go to RESP.
- **RESP:**
  - rsp_valid = 1; rsp_rdata held stable.
  - On rsp_ready go to IDLE; otherwise stay.
- **Outputs decoded from the state register only:**
  - o_action = 2'b11 never occurs.
  - o_action is 2'b00 in IDLE and RESP.
- **Request handshake:**
  - req_ready = 0 in every state except IDLE.
  - req_valid outside IDLE is ignored; the core must hold the request.
- **Address/data bus:**
  - o_address and o_data hold the last latched values between requests.
  - Neither changes except on a request acceptance.
- **Counter:** 4 bits, wraps never; it is cleared on entry to WAIT.
- **rsp_ready before response:** rsp_ready high before or with rsp_valid is legal. The handshake completes in the first RESP cycle.

## Timing
- **Reset values:**
  - State IDLE.
  - o_action = 0, o_address = 0, o_data = 0.
  - rsp_valid = 0, rsp_rdata = 0, busy = 0.
  - req_ready = 1.
- **Store (accepted at edge ending cycle T):**
  - Write strobe in cycle T+1.
  - Next acceptance possible at edge ending cycle T+2.
- **Load (accepted at edge ending cycle T):**
  - Read strobe in T+1.
  - i_data sampled at the edge ending T+1+L.
  - rsp_valid first high in T+2+L.
  - Earliest next acceptance ends T+3+L with immediate rsp_ready.
- **Reset mid-operation:**
  - All outputs drop to reset values asynchronously.
  - Any pending strobe or response is discarded; no partial write is issued after reset release.
- **rsp_rdata** changes only at the capture edge.

## Test plan
- **Reset:** assert rst mid-WAIT → o_action = 00, rsp_valid = 0, busy = 0, and req_ready = 1 immediately; no read data returned after release.
- **Store:** req_valid/req_write = 1, addr 0x0040, wdata 0xBEEF → exactly one cycle of o_action = 10 with o_address = 0x0040, o_data = 0xBEEF; rsp_valid stays 0.
- **Load, L=1:** controller model returns 0x1234 for 0x0010 one cycle after strobe → o_action = 01 one cycle after acceptance; rsp_valid rises 3 cycles after acceptance with rsp_rdata = 0x1234.
- **Load, L=4:** same with 4-cycle model → rsp_valid 6 cycles after acceptance, data 0x1234; i_data garbage in earlier cycles is not captured.
- **Backpressure:** hold rsp_ready = 0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready = 0, o_action = 00 throughout; IDLE on the cycle after rsp_ready = 1.
- **Back-to-back:** store 0x0001 ← 0xAAAA then load 0x0001 with req_valid held continuously → write strobe, then read strobe two cycles later; the memory model returns 0xAAAA.
